// File: rtl/mac_ctrl_multi_if.sv
// Stream handshake bundle between the stream FIFOs and mac_ctrl_multi.
// master: the stream side (drives valids and o_TREADY).
// slave:  the controller (drives readies and the output valid/last).
interface mac_ctrl_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] i_TVALID;
  logic [NUM_CH-1:0] i_TREADY;
  logic [NUM_CH-1:0] k_TVALID;
  logic [NUM_CH-1:0] k_TREADY;
  logic              b_TVALID;
  logic              b_TREADY;
  logic              o_TVALID;
  logic              o_TLAST;
  logic              o_TREADY;

  modport master (
    output i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    input  i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST
  );

  modport slave (
    input  i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    output i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST
  );
endinterface

// File: rtl/mac_ctrl_multi.sv
// Control FSM for the multi-channel MAC datapath: bias load, len taps
// across NUM_CH lock-stepped channel pairs, PIPE-cycle drain, then one
// result per pass; n_out passes per job, o_TLAST on the final result.
// Optional stall counter: define MAC_CTRL_STALL_CNT_EN.
module mac_ctrl_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int PIPE   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] n_out,
  mac_ctrl_multi_if.slave  s,
  output logic             b_enable,
  output logic             acc_enable,
  output logic             busy,
  output logic             done
`ifdef MAC_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, OUT} state_t;

  localparam logic [3:0] PIPE_LAST = (PIPE > 0) ? 4'(PIPE - 1) : 4'd0;

  state_t            state, state_n;
  logic [CNT_W-1:0]  len_q, n_out_q, tap_cnt, out_cnt;
  logic [3:0]        drain_cnt;
  logic              fire, last_tap, last_out;
  logic [NUM_CH-1:0] i_rdy, k_rdy;
  logic              b_rdy, o_vld, o_lst;

  assign fire     = (&s.i_TVALID) & (&s.k_TVALID);
  assign last_tap = (tap_cnt == len_q - CNT_W'(1));
  assign last_out = (out_cnt == n_out_q - CNT_W'(1));

  assign s.i_TREADY = i_rdy;
  assign s.k_TREADY = k_rdy;
  assign s.b_TREADY = b_rdy;
  assign s.o_TVALID = o_vld;
  assign s.o_TLAST  = o_lst;
  assign busy       = (state != IDLE);

  // Next state and handshake/enable decode.
  always_comb begin
    state_n    = state;
    i_rdy      = '0;
    k_rdy      = '0;
    b_rdy      = 1'b0;
    o_vld      = 1'b0;
    o_lst      = 1'b0;
    b_enable   = 1'b0;
    acc_enable = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_n = BIAS;
      BIAS: begin
        b_rdy = 1'b1;
        if (s.b_TVALID) begin
          b_enable = 1'b1;
          state_n  = MAC;
        end
      end
      MAC: begin
        // all-or-nothing so the lanes never skew
        i_rdy      = {NUM_CH{fire}};
        k_rdy      = {NUM_CH{fire}};
        acc_enable = fire;
        if (fire && last_tap) state_n = (PIPE == 0) ? OUT : DRAIN;
      end
      DRAIN: if (drain_cnt == PIPE_LAST) state_n = OUT;
      OUT: begin
        o_vld = 1'b1;
        o_lst = last_out;
        if (s.o_TREADY) begin
          if (last_out) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = BIAS;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, job parameters and sequencing counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      n_out_q   <= '0;
      tap_cnt   <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          len_q   <= (len   == '0) ? CNT_W'(1) : len;
          n_out_q <= (n_out == '0) ? CNT_W'(1) : n_out;
          out_cnt <= '0;
        end
        BIAS: if (s.b_TVALID) tap_cnt <= '0;
        MAC: if (fire) begin
          tap_cnt   <= tap_cnt + CNT_W'(1);
          drain_cnt <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt + 4'd1;
        OUT: if (s.o_TREADY && !last_out) out_cnt <= out_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

`ifdef MAC_CTRL_STALL_CNT_EN
  logic stall;
  assign stall = ((state == MAC)  && !fire) ||
                 ((state == BIAS) && !s.b_TVALID) ||
                 ((state == OUT)  && !s.o_TREADY);

  // Saturating stall counter, cleared when a job is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              stall_cnt <= '0;
    else if (state == IDLE && start)        stall_cnt <= '0;
    else if (stall && stall_cnt != '1)      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mac_ctrl_multi.sv
// Directed bench for mac_ctrl_multi (NUM_CH=4, CNT_W=8, PIPE=2).
module tb_mac_ctrl_multi;
  localparam int NC = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0, n_out = '0;
  logic          b_enable, acc_enable, busy, done;
`ifdef MAC_CTRL_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  mac_ctrl_multi_if #(.NUM_CH(NC)) bus ();

  mac_ctrl_multi #(.NUM_CH(NC), .CNT_W(CW), .PIPE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .n_out(n_out),
    .s(bus.slave), .b_enable(b_enable), .acc_enable(acc_enable),
    .busy(busy), .done(done)
`ifdef MAC_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int nb = 0, na = 0, no = 0, nl = 0, nd = 0, skew = 0;
  int b0, a0, o0, l0, d0;

  // Event counters sampled at the active edge.
  always @(posedge clk) begin
    if (b_enable) nb <= nb + 1;
    if (acc_enable) na <= na + 1;
    if (bus.o_TVALID && bus.o_TREADY) begin
      no <= no + 1;
      if (bus.o_TLAST) nl <= nl + 1;
    end
    if (done) nd <= nd + 1;
    if (((bus.i_TVALID != '1) || (bus.k_TVALID != '1)) &&
        ((|bus.i_TREADY) || (|bus.k_TREADY))) skew <= skew + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b0 = nb; a0 = na; o0 = no; l0 = nl; d0 = nd;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk("idle_timeout", {31'd0, busy}, 0);
    #1;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!bus.o_TVALID && n < 200) begin step(); n++; end
    chk("ov_timeout", {31'd0, bus.o_TVALID}, 1);
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, bus.b_TREADY, bus.i_TREADY, bus.k_TREADY, bus.o_TVALID,
            bus.o_TLAST, b_enable, acc_enable, busy, done};
  endfunction

  task automatic go(input logic [CW-1:0] l, input logic [CW-1:0] n);
    len = l; n_out = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bus.i_TVALID = '1; bus.k_TVALID = '1; bus.b_TVALID = 1'b1; bus.o_TREADY = 1'b1;
    #12;
    chk("reset_outs", outs(), 0);
    reset = 1'b0;
    step();
    chk("idle_outs", outs(), 0);

    // Basic timing: len=3, n_out=1, start in cycle 0.
    len = 8'd3; n_out = 8'd1; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      start = 1'b0;
      #1;
      chk($sformatf("t1_ben_c%0d", c), {31'd0, b_enable}, {31'd0, c == 1});
      chk($sformatf("t1_acc_c%0d", c), {31'd0, acc_enable}, {31'd0, c >= 2 && c <= 4});
      chk($sformatf("t1_ov_c%0d", c), {30'd0, bus.o_TVALID, bus.o_TLAST}, (c == 7) ? 3 : 0);
      chk($sformatf("t1_done_c%0d", c), {31'd0, done}, {31'd0, c == 7});
      chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 7});
    end

    // Partial-valid stall: channel 2 input low for 5 MAC cycles.
    snap();
    go(8'd3, 8'd1);      // cycle 1, BIAS
    step();              // cycle 2, first tap
    step();              // cycle 3, tap_cnt=1
    bus.i_TVALID = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t2_rdy_%0d", i), {24'd0, bus.i_TREADY, bus.k_TREADY}, 0);
      chk($sformatf("t2_acc_%0d", i), {31'd0, acc_enable}, 0);
      step();
    end
    bus.i_TVALID = '1;
    wait_idle();
    chk("t2_acc_total", na - a0, 3);
    chk("t2_outs", no - o0, 1);
`ifdef MAC_CTRL_STALL_CNT_EN
    chk("t2_stall", stall_cnt, 5);
`endif

    // len=0 and n_out=0 behave as 1.
    snap();
    go(8'd0, 8'd0);
    wait_idle();
    chk("t3_bias", nb - b0, 1);
    chk("t3_acc", na - a0, 1);
    chk("t3_outs", no - o0, 1);
    chk("t3_last", nl - l0, 1);
    chk("t3_done", nd - d0, 1);

    // Output backpressure on the 2nd of 3 outputs.
    snap();
    go(8'd2, 8'd3);
    wait_ov();
    chk("t4_last1", {31'd0, bus.o_TLAST}, 0);
    step();
    bus.o_TREADY = 1'b0;
    wait_ov();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_hold_%0d", i), {30'd0, bus.o_TVALID, bus.o_TLAST}, 2);
      chk($sformatf("t4_nodone_%0d", i), {31'd0, done}, 0);
      step();
    end
    bus.o_TREADY = 1'b1;
    #1;
    chk("t4_last2", {30'd0, bus.o_TVALID, bus.o_TLAST}, 2);
    step();
    wait_ov();
    #1;
    chk("t4_last3", {31'd0, bus.o_TLAST}, 1);
    chk("t4_done3", {31'd0, done}, 1);
    step();
    chk("t4_idle", {31'd0, busy}, 0);
    chk("t4_outs", no - o0, 3);
    chk("t4_lasts", nl - l0, 1);
    chk("t4_dones", nd - d0, 1);
`ifdef MAC_CTRL_STALL_CNT_EN
    chk("t4_stall", stall_cnt, 4);
`endif

    // Reset mid-MAC with tap_cnt=1, then a full job.
    go(8'd3, 8'd1);      // cycle 1
    step();              // cycle 2
    step();              // cycle 3
    chk("t5_in_mac", {31'd0, acc_enable}, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_outs", outs(), 0);
`ifdef MAC_CTRL_STALL_CNT_EN
    chk("t5_rst_stall", stall_cnt, 0);
`endif
    step();
    reset = 1'b0;
    step();
    snap();
    go(8'd2, 8'd2);
    wait_idle();
    chk("t5_bias", nb - b0, 2);
    chk("t5_acc", na - a0, 4);
    chk("t5_outs", no - o0, 2);
    chk("t5_done", nd - d0, 1);

    // start while busy is ignored.
    snap();
    bus.b_TVALID = 1'b0;
    go(8'd2, 8'd1);      // cycle 1, BIAS stall
    step();              // cycle 2
    len = 8'd5; n_out = 8'd4; start = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 1);
    chk("t6_noben", {31'd0, b_enable}, 0);
    step();              // cycle 3
    start = 1'b0;
    step();              // cycle 4
    bus.b_TVALID = 1'b1;
    wait_idle();
    chk("t6_acc", na - a0, 2);
    chk("t6_outs", no - o0, 1);
    chk("t6_bias", nb - b0, 1);
`ifdef MAC_CTRL_STALL_CNT_EN
    chk("t6_stall", stall_cnt, 3);
`endif

    chk("skew_ready", skew, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mac_ctrl_multi.md
# mac_ctrl_multi

Parametrised control unit for the multi-channel MAC convolution datapath. It sequences bias load, `len` multiply-accumulate taps across `NUM_CH` lock-stepped input/kernel AXI-Stream channel pairs, and a pipeline drain. It then presents `n_out` results on an output stream with `o_TLAST` on the final result. It sits between the stream FIFOs and the accumulator datapath, and drives its clear, bias-load and accumulate enables.

## Interface
- `NUM_CH`, 4, number of input/kernel channel pairs (≥1)
- `CNT_W`, 8, width of the tap and output counters
- `PIPE`, 2, datapath latency in cycles from last accumulate to valid result (0..15)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  job request; accepted only in IDLE
- `len`  in  CNT_W  taps per output; latched on start; 0 treated as 1
- `n_out`  in  CNT_W  outputs per job; latched on start; 0 treated as 1
- `i_TVALID` / `i_TREADY`  in / out  NUM_CH  input-stream handshakes, one bit per channel
- `k_TVALID` / `k_TREADY`  in / out  NUM_CH  kernel-stream handshakes, one bit per channel
- `b_TVALID` / `b_TREADY`  in / out  1  bias-stream handshake
- `o_TVALID`, `o_TLAST`  out  1  result valid; last result of job
- `o_TREADY`  in  1  downstream ready
- `b_enable`  out  1  load accumulator with bias (clears previous sum)
- `acc_enable`  out  1  accumulate the current tap products
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on the final output transfer
- `stall_cnt`  out  32  stall counter (present only with `MAC_CTRL_STALL_CNT_EN`)

## Operation
- States: IDLE, BIAS, MAC, DRAIN, OUT. Reset → IDLE. Every output resets to 0, and all counters reset to 0.
- IDLE: all readies are 0. `start`=1 latches `len` and `n_out` (0→1), clears `out_cnt`, and moves to BIAS. `start` is ignored in any other state.
- BIAS:
  - `b_TREADY`=1.
  - `b_TVALID`=1: `b_enable`=1 that cycle, `tap_cnt`←0, next state MAC.
- MAC:
  - `fire` = &`i_TVALID` & &`k_TVALID` (AND over all channels).
  - `i_TREADY`, `k_TREADY` = {NUM_CH{`fire`}}. All-or-nothing, so lanes never skew.
  - `acc_enable`=`fire`.
  - On `fire`, `tap_cnt`++. If `fire` and `tap_cnt`==`len_q`-1: go to DRAIN, or straight to OUT when PIPE=0.
- DRAIN: `drain_cnt` counts PIPE cycles, then the FSM moves to OUT. No handshakes are asserted.
- OUT:
  - `o_TVALID`=1; `o_TLAST` = (`out_cnt`==`n_out_q`-1).
  - `o_TVALID` and `o_TLAST` stay stable until `o_TREADY`.
  - On transfer: if last, `done`=1 and the FSM returns to IDLE. Otherwise `out_cnt`++ and the FSM returns to BIAS.
- Readies, `acc_enable`, `b_enable` and `done` are combinational from state and the current valid/ready inputs. `o_TVALID`, `o_TLAST` and `busy` decode from state only.
- Counter wrap: `len_q`/`n_out_q` = 2^CNT_W−1 is legal. Counters compare with equality only and never wrap within a job.
- Reset mid-job: the FSM returns to IDLE immediately and every output goes to 0. The datapath contents are don't-care, because the next BIAS load overwrites them.

## Timing
- `start` in cycle 0 → BIAS in cycle 1. The earliest bias accept is cycle 1.
- Minimum cycles per output, with no stalls: 1 (BIAS) + `len` (MAC) + PIPE (DRAIN) + 1 (OUT).
- A transfer in BIAS or MAC moves state on the next rising edge. There are no back-to-back bias/tap overlaps.
- Partial-valid (some channels valid, others not) is a stall: no channel sees ready and no channel consumes data.
- When `o_TREADY` is already high on entry to OUT, the output transfers in that first OUT cycle.

## Configuration
- `MAC_CTRL_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It increments on every MAC cycle with !`fire`, every BIAS cycle with !`b_TVALID`, and every OUT cycle with !`o_TREADY`.
  - It saturates at 0xFFFF_FFFF, clears on accepted `start`, and resets to 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- NUM_CH=4, PIPE=2, `len`=3, `n_out`=1, all valids and `o_TREADY` held high, `start` at cycle 0:
  - `b_enable` in cycle 1.
  - `acc_enable` in cycles 2–4.
  - `o_TVALID`=`o_TLAST`=1 in cycle 7.
  - `done` in cycle 7; `busy` low in cycle 8.
- Channel 2 `i_TVALID` held low for 5 cycles mid-MAC:
  - All `i_TREADY`/`k_TREADY` stay 0 and `acc_enable` stays 0 for those 5 cycles.
  - Exactly 3 accumulates in total.
  - `stall_cnt`=5 when enabled.
- `len`=0 and `n_out`=0 behave as 1: one bias load, one accumulate, one output with `o_TLAST`=1.
- `n_out`=3, `len`=2, `o_TREADY` low for 4 cycles on the 2nd output:
  - `o_TVALID` stays high and `o_TLAST` stays 0 for those cycles.
  - `o_TLAST`=1 only on the 3rd output; `done` once.
- Assert `reset` in MAC with `tap_cnt`=1:
  - The FSM is in IDLE and all outputs are 0 in the same cycle.
  - A following `start` runs a complete, correct job.
- `start` pulsed while `busy`=1: ignored. The latched `len`/`n_out` are unchanged and `stall_cnt` is not cleared.
